// File: rtl/mc_controller.sv
// Multicycle RV32I control FSM: sequences fetch/decode/execute/memory/writeback and decodes ALU ops.
// Optional MC_CONTROLLER_BNE_EN adds bne (funct3=001) to the branch state.
module mc_controller (
   input  logic       clk,
   input  logic       reset,
   input  logic [6:0] op,
   input  logic [2:0] funct3,
   input  logic       funct7b5,
   input  logic       Zero_flag,
   output logic       PCWrite,
   output logic       AdrSrc,
   output logic       MemWrite,
   output logic       IRWrite,
   output logic       RegWrite,
   output logic [1:0] ResultSrc,
   output logic [1:0] ALUSrcA,
   output logic [1:0] ALUSrcB,
   output logic [1:0] ImmSrc,
   output logic [2:0] ALU_control,
   output logic       illegal_instr,
   output logic [3:0] state_dbg
);

   typedef enum logic [3:0] {
      StFetch    = 4'd0,
      StDecode   = 4'd1,
      StMemAdr   = 4'd2,
      StMemRead  = 4'd3,
      StMemWb    = 4'd4,
      StMemWrite = 4'd5,
      StExecR    = 4'd6,
      StExecI    = 4'd7,
      StAluWb    = 4'd8,
      StBeq      = 4'd9,
      StJal      = 4'd10
   } state_e;

   localparam logic [6:0] OpLoad   = 7'b0000011;
   localparam logic [6:0] OpStore  = 7'b0100011;
   localparam logic [6:0] OpRtype  = 7'b0110011;
   localparam logic [6:0] OpItype  = 7'b0010011;
   localparam logic [6:0] OpBranch = 7'b1100011;
   localparam logic [6:0] OpJal    = 7'b1101111;

   state_e     state_q, state_d, decode_next;
   logic       pc_update, branch, mem_write_s, ir_write_s, reg_write_s;
   logic       decode_bad, branch_ok, branch_take;
   logic [1:0] alu_op;

   always_ff @(posedge clk) begin
      if (reset) state_q <= StFetch;
      else       state_q <= state_d;
   end

`ifdef MC_CONTROLLER_BNE_EN
   assign branch_ok   = (funct3 == 3'b000) || (funct3 == 3'b001);
   assign branch_take = (funct3 == 3'b001) ? ~Zero_flag : Zero_flag;
`else
   assign branch_ok   = (funct3 == 3'b000);
   assign branch_take = Zero_flag;
`endif

   always_comb begin
      decode_next = StFetch;
      decode_bad  = 1'b0;
      case (op)
         OpLoad, OpStore: decode_next = StMemAdr;
         OpRtype:         decode_next = StExecR;
         OpItype:         decode_next = StExecI;
         OpJal:           decode_next = StJal;
         OpBranch: begin
            if (branch_ok) decode_next = StBeq;
            else           decode_bad  = 1'b1;
         end
         default:         decode_bad  = 1'b1;
      endcase
   end

   always_comb begin
      state_d     = StFetch;
      pc_update   = 1'b0;
      branch      = 1'b0;
      AdrSrc      = 1'b0;
      mem_write_s = 1'b0;
      ir_write_s  = 1'b0;
      reg_write_s = 1'b0;
      ResultSrc   = 2'b00;
      ALUSrcA     = 2'b00;
      ALUSrcB     = 2'b00;
      alu_op      = 2'b00;
      case (state_q)
         StFetch: begin
            ir_write_s = 1'b1;
            ALUSrcB    = 2'b10;
            ResultSrc  = 2'b10;
            pc_update  = 1'b1;
            state_d    = StDecode;
         end
         StDecode: begin
            ALUSrcA = 2'b01;
            ALUSrcB = 2'b01;
            state_d = decode_next;
         end
         StMemAdr: begin
            ALUSrcA = 2'b10;
            ALUSrcB = 2'b01;
            state_d = op[5] ? StMemWrite : StMemRead;
         end
         StMemRead: begin
            AdrSrc  = 1'b1;
            state_d = StMemWb;
         end
         StMemWb: begin
            ResultSrc   = 2'b01;
            reg_write_s = 1'b1;
         end
         StMemWrite: begin
            AdrSrc      = 1'b1;
            mem_write_s = 1'b1;
         end
         StExecR: begin
            ALUSrcA = 2'b10;
            alu_op  = 2'b10;
            state_d = StAluWb;
         end
         StExecI: begin
            ALUSrcA = 2'b10;
            ALUSrcB = 2'b01;
            alu_op  = 2'b10;
            state_d = StAluWb;
         end
         StAluWb: reg_write_s = 1'b1;
         StBeq: begin
            ALUSrcA = 2'b10;
            alu_op  = 2'b01;
            branch  = 1'b1;
         end
         StJal: begin
            ALUSrcA   = 2'b01;
            ALUSrcB   = 2'b10;
            pc_update = 1'b1;
            state_d   = StAluWb;
         end
         default: state_d = StFetch;
      endcase
   end

   // Write enables and the illegal pulse are gated directly by reset so nothing escapes mid-abort.
   assign PCWrite       = ~reset & (pc_update | (branch & branch_take));
   assign MemWrite      = ~reset & mem_write_s;
   assign IRWrite       = ~reset & ir_write_s;
   assign RegWrite      = ~reset & reg_write_s;
   assign illegal_instr = ~reset & (state_q == StDecode) & decode_bad;
   assign state_dbg     = state_q;

   always_comb begin
      ALU_control = 3'b000;
      case (alu_op)
         2'b00: ALU_control = 3'b000;
         2'b01: ALU_control = 3'b001;
         default: begin
            case (funct3)
               3'b000:  ALU_control = (op[5] & funct7b5) ? 3'b001 : 3'b000;
               3'b010:  ALU_control = 3'b101;
               3'b110:  ALU_control = 3'b011;
               3'b111:  ALU_control = 3'b010;
               default: ALU_control = 3'b000;
            endcase
         end
      endcase
   end

   always_comb begin
      case (op)
         OpStore:  ImmSrc = 2'b01;
         OpBranch: ImmSrc = 2'b10;
         OpJal:    ImmSrc = 2'b11;
         default:  ImmSrc = 2'b00;
      endcase
   end

endmodule

// File: tb/tb_mc_controller.sv
// Bench for mc_controller: directed instruction table, reset corner cases, random instruction stream.
module tb_mc_controller;

   logic       clk = 1'b0;
   logic       reset;
   logic [6:0] op;
   logic [2:0] funct3;
   logic       funct7b5;
   logic       Zero_flag;
   logic       PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, illegal_instr;
   logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ImmSrc;
   logic [2:0] ALU_control;
   logic [3:0] state_dbg;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   mc_controller dut (
      .clk(clk), .reset(reset), .op(op), .funct3(funct3), .funct7b5(funct7b5),
      .Zero_flag(Zero_flag), .PCWrite(PCWrite), .AdrSrc(AdrSrc), .MemWrite(MemWrite),
      .IRWrite(IRWrite), .RegWrite(RegWrite), .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA),
      .ALUSrcB(ALUSrcB), .ImmSrc(ImmSrc), .ALU_control(ALU_control),
      .illegal_instr(illegal_instr), .state_dbg(state_dbg)
   );

   // {PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc, ALUSrcA, ALUSrcB, ImmSrc, ALU, ill}
   typedef logic [17:0] outs_t;

   typedef struct packed {
      logic [6:0]  op;
      logic [2:0]  f3;
      logic        f7;
      logic        z;
      logic [2:0]  n;
      logic [19:0] seq;  // state visited in cycle i sits in nibble i
   } vec_t;

   // Instruction-level view: which states an instruction walks through.
   function automatic logic [22:0] model_seq(input logic [6:0] o, input logic [2:0] f3);
      logic bok;
`ifdef MC_CONTROLLER_BNE_EN
      bok = (f3 == 3'd0) || (f3 == 3'd1);
`else
      bok = (f3 == 3'd0);
`endif
      case (o)
         7'b0000011: return {3'd5, 20'h43210};
         7'b0100011: return {3'd4, 20'h05210};
         7'b0110011: return {3'd4, 20'h08610};
         7'b0010011: return {3'd4, 20'h08710};
         7'b1101111: return {3'd4, 20'h08A10};
         7'b1100011: return bok ? {3'd3, 20'h00910} : {3'd2, 20'h00010};
         default:    return {3'd2, 20'h00010};
      endcase
   endfunction

   function automatic outs_t model_out(input int st, input logic [6:0] o, input logic [2:0] f3,
                                       input logic f7, input logic z, input logic rst);
      logic pcw, adr, mw, irw, rw, ill, take;
      logic [1:0] rs, sa, sb, imm;
      int aluop;
      logic [2:0] alu;
      logic [22:0] sq;
      pcw = 0; adr = 0; mw = 0; irw = 0; rw = 0; ill = 0;
      rs = 0; sa = 0; sb = 0; aluop = 0;
      sq = model_seq(o, f3);
`ifdef MC_CONTROLLER_BNE_EN
      take = (f3 == 3'd1) ? !z : z;
`else
      take = z;
`endif
      case (st)
         0: begin irw = 1; sb = 2; rs = 2; pcw = 1; end
         1: begin sa = 1; sb = 1; ill = (sq[22:20] == 3'd2); end
         2: begin sa = 2; sb = 1; end
         3: adr = 1;
         4: begin rs = 1; rw = 1; end
         5: begin adr = 1; mw = 1; end
         6: begin sa = 2; aluop = 2; end
         7: begin sa = 2; sb = 1; aluop = 2; end
         8: rw = 1;
         9: begin sa = 2; aluop = 1; pcw = take; end
         10: begin sa = 1; sb = 2; pcw = 1; end
         default: ;
      endcase
      if (aluop == 0)      alu = 3'b000;
      else if (aluop == 1) alu = 3'b001;
      else if (f3 == 3'd0) alu = (o == 7'b0110011 && f7) ? 3'b001 : 3'b000;
      else if (f3 == 3'd2) alu = 3'b101;
      else if (f3 == 3'd6) alu = 3'b011;
      else if (f3 == 3'd7) alu = 3'b010;
      else                 alu = 3'b000;
      if (o == 7'b0100011)      imm = 2'b01;
      else if (o == 7'b1100011) imm = 2'b10;
      else if (o == 7'b1101111) imm = 2'b11;
      else                      imm = 2'b00;
      if (rst) begin pcw = 0; mw = 0; irw = 0; rw = 0; ill = 0; end
      return {pcw, adr, mw, irw, rw, rs, sa, sb, imm, alu, ill};
   endfunction

   function automatic outs_t dut_out();
      return {PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc, ALUSrcA, ALUSrcB,
              ImmSrc, ALU_control, illegal_instr};
   endfunction

   task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h expected=%h", nm, got, exp);
      end
   endtask

   // Starts just after a rising edge with the DUT in FETCH; checks every cycle at mid-period.
   task automatic run_instr(input string nm, input logic [6:0] o, input logic [2:0] f3,
                            input logic f7, input logic z, input logic rand_z,
                            input logic use_tab, input logic [2:0] tn, input logic [19:0] tseq,
                            input int max_cyc);
      logic [22:0] sq;
      int n, st;
      sq = model_seq(o, f3);
      n = use_tab ? int'(tn) : int'(sq[22:20]);
      if (n > max_cyc) n = max_cyc;
      op = o; funct3 = f3; funct7b5 = f7;
      for (int i = 0; i < n; i++) begin
         Zero_flag = rand_z ? 1'($urandom) : z;
         #4;
         st = use_tab ? int'(tseq[4*i +: 4]) : int'(sq[4*i +: 4]);
         check({nm, "_state"}, 32'(state_dbg), 32'(st));
         check({nm, "_outs"}, 32'(dut_out()), 32'(model_out(st, o, f3, f7, Zero_flag, 1'b0)));
         @(posedge clk); #1;
      end
   endtask

   vec_t tab[9];
   logic [6:0] ops[6];

   initial begin
      tab[0] = '{op: 7'b0110011, f3: 3'd0, f7: 1'b1, z: 1'b0, n: 3'd4, seq: 20'h08610};
      tab[1] = '{op: 7'b0000011, f3: 3'd2, f7: 1'b0, z: 1'b0, n: 3'd5, seq: 20'h43210};
      tab[2] = '{op: 7'b0100011, f3: 3'd2, f7: 1'b0, z: 1'b0, n: 3'd4, seq: 20'h05210};
      tab[3] = '{op: 7'b1100011, f3: 3'd0, f7: 1'b0, z: 1'b1, n: 3'd3, seq: 20'h00910};
      tab[4] = '{op: 7'b1100011, f3: 3'd0, f7: 1'b0, z: 1'b0, n: 3'd3, seq: 20'h00910};
      tab[5] = '{op: 7'b0010011, f3: 3'd2, f7: 1'b0, z: 1'b0, n: 3'd4, seq: 20'h08710};
      tab[6] = '{op: 7'b1101111, f3: 3'd5, f7: 1'b1, z: 1'b0, n: 3'd4, seq: 20'h08A10};
      tab[7] = '{op: 7'b1111111, f3: 3'd0, f7: 1'b0, z: 1'b0, n: 3'd2, seq: 20'h00010};
`ifdef MC_CONTROLLER_BNE_EN
      tab[8] = '{op: 7'b1100011, f3: 3'd1, f7: 1'b0, z: 1'b0, n: 3'd3, seq: 20'h00910};
`else
      tab[8] = '{op: 7'b1100011, f3: 3'd1, f7: 1'b0, z: 1'b0, n: 3'd2, seq: 20'h00010};
`endif
      ops = '{7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011, 7'b1100011, 7'b1101111};

      reset = 1'b1; op = '0; funct3 = '0; funct7b5 = 1'b0; Zero_flag = 1'b1;
      for (int i = 0; i < 2; i++) begin
         @(posedge clk); #4;
         check("rst_state", 32'(state_dbg), 32'd0);
         check("rst_wen", 32'({PCWrite, MemWrite, RegWrite, IRWrite}), 32'd0);
         check("rst_outs", 32'(dut_out()), 32'(model_out(0, op, funct3, 1'b0, 1'b1, 1'b1)));
      end
      @(posedge clk); #1;
      reset = 1'b0;
      #4;
      check("rel_fetch", 32'({IRWrite, PCWrite, ALUSrcB}), 32'b1110);
      @(negedge clk);
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;

      for (int i = 0; i < 9; i++)
         run_instr($sformatf("vec%0d", i), tab[i].op, tab[i].f3, tab[i].f7, tab[i].z, 1'b0,
                   1'b1, tab[i].n, tab[i].seq, 8);

      // Reset while in MEMWRITE: the store must not be written and the FSM restarts.
      run_instr("sw_pre", 7'b0100011, 3'd2, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 20'h0, 3);
      reset = 1'b1;
      #4;
      check("midrst_state", 32'(state_dbg), 32'd5);
      check("midrst_memw", 32'(MemWrite), 32'd0);
      check("midrst_outs", 32'(dut_out()), 32'(model_out(5, op, funct3, 1'b0, Zero_flag, 1'b1)));
      @(posedge clk); #4;
      check("midrst_next", 32'(state_dbg), 32'd0);
      @(posedge clk); #1;
      reset = 1'b0;

      for (int k = 0; k < 300; k++) begin
         logic [6:0] o;
         o = ($urandom_range(0, 7) < 6) ? ops[$urandom_range(0, 5)] : 7'($urandom);
         run_instr("rand", o, 3'($urandom), 1'($urandom), 1'b0, 1'b1, 1'b0, 3'd0, 20'h0, 8);
      end
      #4;
      check("end_state", 32'(state_dbg), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
